// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address width helper,
// default sizes and the read-port source priority used by the hazard unit.
package regfile_pkg;

  localparam int DEFAULT_DW    = 32;
  localparam int DEFAULT_DEPTH = 32;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  typedef enum logic [1:0] {
    RD_SRC_ZERO  = 2'd0,
    RD_SRC_WB1   = 2'd1,
    RD_SRC_WB0   = 2'd2,
    RD_SRC_ARRAY = 2'd3
  } rd_src_e;

  // WB1 is the younger instruction, so its data supersedes WB0 when both match.
  function automatic rd_src_e rd_src(input logic zero_hit, input logic wb1_hit,
                                     input logic wb0_hit);
    if (zero_hit)     return RD_SRC_ZERO;
    else if (wb1_hit) return RD_SRC_WB1;
    else if (wb0_hit) return RD_SRC_WB0;
    else              return RD_SRC_ARRAY;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback; a set
// wins over a same-cycle clear of the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr0_en,
  input  logic [AW-1:0]    clr0_addr,
  input  logic             clr1_en,
  input  logic [AW-1:0]    clr1_addr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_next;

  // NOTE: start from the held value so every path assigns busy_next; no latch.
  always_comb begin
    busy_next = busy;
    if (clr0_en) busy_next[clr0_addr] = 1'b0;
    if (clr1_en) busy_next[clr1_addr] = 1'b0;
    if (set_en)  busy_next[set_addr]  = 1'b1;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  // NOTE: state flops use non-blocking assignment so all edges update together.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with WB1-over-WB0 bypass, optional zero
// register and busy scoreboard. Define REGFILE_MP_DBG_EN to add a debug port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEFAULT_DW,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] ra,
  output logic [NUM_RD*DW-1:0] rd,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [DW-1:0]        wd0,
  input  logic                 clr0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [DW-1:0]        wd1,
  input  logic                 clr1,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic [DEPTH-1:0]     busy
`ifdef REGFILE_MP_DBG_EN
  ,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [DW-1:0]        dbg_wdata,
  output logic                 dbg_ack,
  output logic [DW-1:0]        dbg_rdata
`endif
);

  logic [DW-1:0] mem [DEPTH];

  logic wr0_ok, wr1_ok;
  assign wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0));
  assign wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));

`ifdef REGFILE_MP_DBG_EN
  logic dbg_accept, dbg_wr_ok;
  // Blocking on dbg_ack keeps a still-held request from being taken twice.
  assign dbg_accept = dbg_req && !we0 && !we1 && !dbg_ack;
  assign dbg_wr_ok  = dbg_accept && dbg_we && !((ZERO_REG != 0) && (dbg_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_accept;
      if (dbg_accept) dbg_rdata <= mem[dbg_addr];
    end
  end
`endif

  // NOTE: the array is cleared by reset, so it maps to flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      if (wr0_ok) mem[wa0] <= wd0;
      if (wr1_ok) mem[wa1] <= wd1;
`ifdef REGFILE_MP_DBG_EN
      if (dbg_wr_ok) mem[dbg_addr] <= dbg_wdata;
`endif
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] addr;
    rd_src_e       src;
    assign addr = ra[i*AW +: AW];
    // Reset shares the zero path, which also suppresses bypass while rst is high.
    assign src  = rd_src(rst || ((ZERO_REG != 0) && (addr == '0)),
                         we1 && (wa1 == addr), we0 && (wa0 == addr));
    always_comb begin
      unique case (src)
        RD_SRC_ZERO: rd[i*DW +: DW] = '0;
        RD_SRC_WB1:  rd[i*DW +: DW] = wd1;
        RD_SRC_WB0:  rd[i*DW +: DW] = wd0;
        default:     rd[i*DW +: DW] = mem[addr];
      endcase
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr0_en  (we0 && clr0),
    .clr0_addr(wa0),
    .clr1_en  (we1 && clr1),
    .clr1_addr(wa1),
    .set_en   (iss_valid),
    .set_addr (iss_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a default instance plus a
// 4-read-port, 64-entry instance; debug-port checks when REGFILE_MP_DBG_EN is set.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance: DW=32, DEPTH=32, NUM_RD=2, ZERO_REG=1.
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        we0, we1, clr0, clr1, iss_valid;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [31:0] busy;

  // Wide instance: DEPTH=64, NUM_RD=4.
  logic [23:0]  b_ra;
  logic [127:0] b_rd;
  logic         b_we0, b_we1, b_clr0, b_clr1, b_iss_valid;
  logic [5:0]   b_wa0, b_wa1, b_iss_addr;
  logic [31:0]  b_wd0, b_wd1;
  logic [63:0]  b_busy;

`ifdef REGFILE_MP_DBG_EN
  logic        dbg_req, dbg_we, dbg_ack;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        b_dbg_ack;
  logic [31:0] b_dbg_rdata;
`endif

  regfile_mp dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd),
    .we0(we0), .wa0(wa0), .wd0(wd0), .clr0(clr0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .clr1(clr1),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .busy(busy)
`ifdef REGFILE_MP_DBG_EN
    , .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
`endif
  );

  regfile_mp #(.DEPTH(64), .NUM_RD(4)) dut_b (
    .clk(clk), .rst(rst), .ra(b_ra), .rd(b_rd),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .clr0(b_clr0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1), .clr1(b_clr1),
    .iss_valid(b_iss_valid), .iss_addr(b_iss_addr), .busy(b_busy)
`ifdef REGFILE_MP_DBG_EN
    , .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(6'd0),
    .dbg_wdata(32'd0), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; clr0 = 0; clr1 = 0; iss_valid = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
`ifdef REGFILE_MP_DBG_EN
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
`endif
  endtask

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Storage starts cleared by the reset sequence below.
    vecs[0] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd3, 32'h22,   5'd3,  5'd4,  32'h22,       32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd3,  5'd0,  32'h22,       32'h0};
    vecs[2] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd5, 32'h55,   5'd4,  5'd5,  32'h44,       32'h55};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hDEAD, 5'd0,  5'd4,  32'h0,        32'h44};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd0,  5'd5,  32'h0,        32'h55};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFF0000, 1'b0, 5'd0, 32'h0,    5'd31, 5'd3,  32'hFFFF0000, 32'h22};
    vecs[6] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4, 32'h66,   5'd4,  5'd3,  32'h66,       32'h33};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd3,  5'd4,  32'h33,       32'h66};
    vecs[8] = '{1'b1, 5'd0,  32'h1,        1'b0, 5'd0, 32'h0,    5'd0,  5'd31, 32'h0,        32'hFFFF0000};

    rst = 0; ra = 0; idle();
    b_ra = 0; b_we0 = 0; b_we1 = 0; b_clr0 = 0; b_clr1 = 0; b_iss_valid = 0;
    b_wa0 = 0; b_wa1 = 0; b_wd0 = 0; b_wd1 = 0; b_iss_addr = 0;
    tick();

    // Fill every register with all-ones so reset has something to clear.
    for (int i = 0; i < 16; i++) begin
      we0 = 1; wa0 = 5'(2*i);   wd0 = 32'hFFFFFFFF;
      we1 = 1; wa1 = 5'(2*i+1); wd1 = 32'hFFFFFFFF;
      tick();
    end
    idle();
    ra = {5'd6, 5'd6};
    #1 check("prefill_x6", rd[31:0], 32'hFFFFFFFF);

    // Reset cycle: output forced to 0, bypass disabled, write ignored.
    rst = 1; we1 = 1; wa1 = 5; wd1 = 32'h55; ra = {5'd6, 5'd5};
    #1;
    check("rst_rd0_bypass_off", rd[31:0], 32'h0);
    check("rst_rd1_forced", rd[63:32], 32'h0);
    tick();
    rst = 0; idle();
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a+1), 5'(a)};
      #1;
      check($sformatf("post_rst_x%0d", a), rd[31:0], 32'h0);
      check($sformatf("post_rst_x%0d", a+1), rd[63:32], 32'h0);
    end
    check("post_rst_busy", {32'h0, busy}, 64'h0);
    check("post_rst_busy_b", b_busy, 64'h0);

    // Table-driven read/bypass vectors; each commits its writes at the edge.
    for (int i = 0; i < 9; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      ra  = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), rd[31:0], vecs[i].exp0);
      check($sformatf("vec%0d_rd1", i), rd[63:32], vecs[i].exp1);
      tick();
    end
    idle();

    // Zero register ignores write and issue.
    we1 = 1; wa1 = 0; wd1 = 32'hDEAD; iss_valid = 1; iss_addr = 0; ra = {5'd0, 5'd0};
    #1 check("zero_rd_bypass", rd[31:0], 32'h0);
    tick(); idle();
    check("zero_rd_after", rd[31:0], 32'h0);
    check("zero_busy0", {63'h0, busy[0]}, 64'h0);

    // Set beats same-cycle clear; later clear on port 1 releases it.
    iss_valid = 1; iss_addr = 7;
    tick(); idle();
    check("iss_x7", {32'h0, busy}, 64'h80);
    iss_valid = 1; iss_addr = 7; we0 = 1; clr0 = 1; wa0 = 7; wd0 = 32'h77;
    tick(); idle();
    check("set_wins_x7", {32'h0, busy}, 64'h80);
    we1 = 1; clr1 = 1; wa1 = 7; wd1 = 32'h78; ra = {5'd0, 5'd7};
    tick(); idle();
    check("clr1_x7", {32'h0, busy}, 64'h0);
    check("clr1_x7_data", rd[31:0], 32'h78);

    // Clear of idle reg is a no-op; dual clear idempotent; clr=0 keeps busy.
    we0 = 1; clr0 = 1; wa0 = 9; wd0 = 32'h9;
    tick(); idle();
    check("clr_idle_x9", {32'h0, busy}, 64'h0);
    iss_valid = 1; iss_addr = 9;
    tick(); idle();
    iss_valid = 1; iss_addr = 10;
    we0 = 1; clr0 = 1; wa0 = 9; we1 = 1; clr1 = 1; wa1 = 9; wd1 = 32'h99;
    tick(); idle();
    check("dual_clr_x9", {32'h0, busy}, 64'h400);
    we0 = 1; clr0 = 0; wa0 = 10; wd0 = 32'hA;
    tick(); idle();
    check("no_clr_x10", {32'h0, busy}, 64'h400);
    ra = {5'd10, 5'd9};
    #1 check("data_x10", rd[63:32], 32'hA);

    // Reset mid-operation discards busy bits and data.
    iss_valid = 1; iss_addr = 11; we0 = 1; wa0 = 12; wd0 = 32'hC; rst = 1;
    tick(); rst = 0; idle();
    check("midrst_busy", {32'h0, busy}, 64'h0);
    ra = {5'd10, 5'd12};
    #1 check("midrst_x12", rd[31:0], 32'h0);
    check("midrst_x10", rd[63:32], 32'h0);

    // Wide instance: four ports, port 1 bypasses the WB0 write of x63.
    b_we0 = 1; b_wa0 = 1;  b_wd0 = 32'h1111;
    b_we1 = 1; b_wa1 = 2;  b_wd1 = 32'h2222;
    tick();
    b_we0 = 1; b_wa0 = 63; b_wd0 = 32'h12345678; b_we1 = 0;
    tick();
    b_we0 = 1; b_wa0 = 63; b_wd0 = 32'hA5A5A5A5;
    b_ra = {6'd1, 6'd2, 6'd63, 6'd1};
    #1;
    check("b_rd0_x1", {32'h0, b_rd[31:0]}, 64'h1111);
    check("b_rd1_x63_bypass", {32'h0, b_rd[63:32]}, 64'hA5A5A5A5);
    check("b_rd2_x2", {32'h0, b_rd[95:64]}, 64'h2222);
    check("b_rd3_x1", {32'h0, b_rd[127:96]}, 64'h1111);
    tick();
    b_we0 = 0;
    #1 check("b_rd1_x63_stored", {32'h0, b_rd[63:32]}, 64'hA5A5A5A5);

`ifdef REGFILE_MP_DBG_EN
    // Debug read waits while writeback is active, then acks for one cycle.
    we0 = 1; wa0 = 9; wd0 = 32'h99;
    tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 9;
    for (int c = 0; c < 3; c++) begin
      we0 = 1; wa0 = 20; wd0 = 32'(c);
      tick();
      check($sformatf("dbg_wait%0d_ack", c), {63'h0, dbg_ack}, 64'h0);
    end
    we0 = 0;
    tick();
    check("dbg_ack", {63'h0, dbg_ack}, 64'h1);
    check("dbg_rdata", {32'h0, dbg_rdata}, 64'h99);
    tick();
    check("dbg_ack_pulse", {63'h0, dbg_ack}, 64'h0);
    dbg_req = 0;
    tick();
    check("dbg_ack_idle", {63'h0, dbg_ack}, 64'h0);

    // Debug write updates data, leaves busy alone; x0 stays zero.
    iss_valid = 1; iss_addr = 12;
    tick(); iss_valid = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12; dbg_wdata = 32'hC0DE;
    tick();
    check("dbgw_ack", {63'h0, dbg_ack}, 64'h1);
    dbg_req = 0; dbg_we = 0;
    ra = {5'd0, 5'd12};
    #1 check("dbgw_x12", rd[31:0], 32'hC0DE);
    check("dbgw_busy", {32'h0, busy}, 64'h1000);
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 0; dbg_wdata = 32'hBAD;
    tick();
    dbg_req = 0; dbg_we = 0;
    tick();
    dbg_req = 1; dbg_addr = 0;
    tick();
    check("dbg_x0_rdata", {32'h0, dbg_rdata}, 64'h0);
    idle();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
